// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the 1-to-4 TDM demultiplexer.
//   state_t    - framing FSM states (HUNT: searching for frame_sync, RUN: locked)
//   NUM_SLOTS  - channels per TDM frame
//   SLOT_W     - width of the slot index
package tdm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 2;

endpackage

// File: rtl/tdm_slot_counter.sv
// tdm_slot_counter: slot index for the next expected valid beat.
//   clk   - clock, rising edge
//   rst   - synchronous active-high reset, clears the index
//   clr   - clear the index to 0
//   load1 - load 1 (a slot-0 beat has just been taken)
//   inc   - advance by one; 3 wraps to 0 through the natural 2-bit rollover
//   slot  - current slot index
// Priority: rst/clr > load1 > inc.
module tdm_slot_counter
    import tdm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load1,
    input  logic              inc,
    output logic [SLOT_W-1:0] slot
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            slot <= '0;
        end else if (load1) begin
            slot <= SLOT_W'(1);
        end else if (inc) begin
            slot <= slot + SLOT_W'(1);
        end
    end

endmodule

// File: rtl/tdm_demux1to4.sv
// tdm_demux1to4: splits a time-multiplexed stream (one channel per valid
// beat, channel 0 marked by frame_sync) into four parallel channel outputs.
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   din        - sample stream, W bits
//   din_valid  - din carries a beat this cycle
//   frame_sync - with din_valid, marks the channel-0 beat
//   q0..q3     - channels of the last complete frame
//   q_valid    - one-cycle pulse when q0..q3 update
//   slot       - slot expected for the next valid beat
//   locked     - high while in RUN
//   sync_err   - one-cycle pulse on a framing violation
// Slots 0..2 are collected in shadow registers; the slot-3 beat moves the
// whole frame to q0..q3 in one edge so the outputs never show a mixed frame.
module tdm_demux1to4
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [W-1:0]      q0,
    output logic [W-1:0]      q1,
    output logic [W-1:0]      q2,
    output logic [W-1:0]      q3,
    output logic              q_valid,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic              sync_err
);

    state_t             state;
    logic [SLOT_W-1:0]  slot_cnt;
    logic [W-1:0]       shadow [NUM_SLOTS-1];

    logic store_first;
    logic store_mid;
    logic frame_done;
    logic frame_err;
    logic go_run;
    logic go_hunt;
    logic cnt_clr;
    logic cnt_load1;
    logic cnt_inc;

    // Per-beat action decode; nothing happens without din_valid, which also
    // makes frame_sync alone a no-op.
    always_comb begin
        store_first = 1'b0;
        store_mid   = 1'b0;
        frame_done  = 1'b0;
        frame_err   = 1'b0;
        go_run      = 1'b0;
        go_hunt     = 1'b0;
        cnt_clr     = 1'b0;
        cnt_load1   = 1'b0;
        cnt_inc     = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (frame_sync) begin
                        store_first = 1'b1;
                        cnt_load1   = 1'b1;
                        go_run      = 1'b1;
                    end
                end
                RUN: begin
                    if (frame_sync) begin
                        // A sync anywhere but slot 0 abandons the partial
                        // frame and restarts on this beat.
                        store_first = 1'b1;
                        cnt_load1   = 1'b1;
                        frame_err   = (slot_cnt != '0);
                    end else if (slot_cnt == '0) begin
                        // Expected a sync and got none: lock is lost.
                        frame_err = 1'b1;
                        go_hunt   = 1'b1;
                        cnt_clr   = 1'b1;
                    end else if (slot_cnt == SLOT_W'(NUM_SLOTS - 1)) begin
                        frame_done = 1'b1;
                        cnt_inc    = 1'b1;
                    end else begin
                        store_mid = 1'b1;
                        cnt_inc   = 1'b1;
                    end
                end
                default: begin
                    go_hunt = 1'b1;
                    cnt_clr = 1'b1;
                end
            endcase
        end
    end

    tdm_slot_counter u_slot_counter (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .slot  (slot_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            q_valid  <= 1'b0;
            sync_err <= 1'b0;
            q0       <= '0;
            q1       <= '0;
            q2       <= '0;
            q3       <= '0;
            for (int i = 0; i < NUM_SLOTS - 1; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            q_valid  <= frame_done;
            sync_err <= frame_err;
            if (go_run) begin
                state <= RUN;
            end else if (go_hunt) begin
                state <= HUNT;
            end
            if (store_first) begin
                shadow[0] <= din;
            end
            if (store_mid) begin
                shadow[slot_cnt] <= din;
            end
            if (frame_done) begin
                q0 <= shadow[0];
                q1 <= shadow[1];
                q2 <= shadow[2];
                q3 <= din;
            end
        end
    end

    assign slot   = slot_cnt;
    assign locked = (state == RUN);

endmodule

// File: tb/tb_tdm_demux1to4.sv
// tb_tdm_demux1to4: drives a W=8 and a W=1 instance of tdm_demux1to4 with the
// same stream (the W=1 instance sees bit 0) and compares both, every cycle,
// against a frame-collecting queue model; directed scenarios add literal
// expectations.
module tb_tdm_demux1to4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = '0;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;

    logic [7:0] q0, q1, q2, q3;
    logic       q_valid, locked, sync_err;
    logic [1:0] slot;

    logic       b0, b1, b2, b3;
    logic       bq_valid, blocked, bsync_err;
    logic [1:0] bslot;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    tdm_demux1to4 #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
        .q_valid(q_valid), .slot(slot), .locked(locked), .sync_err(sync_err)
    );

    tdm_demux1to4 #(.W(1)) dut1 (
        .clk(clk), .rst(rst), .din(din[0:0]), .din_valid(din_valid),
        .frame_sync(frame_sync), .q0(b0), .q1(b1), .q2(b2), .q3(b3),
        .q_valid(bq_valid), .slot(bslot), .locked(blocked), .sync_err(bsync_err)
    );

    // Reference model: beats of the frame in progress are kept in a queue.
    logic [7:0] fr[$];
    logic [7:0] exp_q [4];
    logic       exp_qv = 1'b0;
    logic       exp_err = 1'b0;
    logic       exp_locked = 1'b0;
    logic       chk_en = 1'b0;

    function automatic int exp_slot();
        return exp_locked ? fr.size() : 0;
    endfunction

    always @(posedge clk) begin
        exp_qv  = 1'b0;
        exp_err = 1'b0;
        if (rst) begin
            chk_en     = 1'b1;
            exp_locked = 1'b0;
            fr.delete();
            for (int i = 0; i < 4; i++) exp_q[i] = '0;
        end else if (din_valid) begin
            if (frame_sync) begin
                if (exp_locked && fr.size() != 0) exp_err = 1'b1;
                fr.delete();
                fr.push_back(din);
                exp_locked = 1'b1;
            end else if (exp_locked) begin
                if (fr.size() == 0) begin
                    exp_err    = 1'b1;
                    exp_locked = 1'b0;
                end else begin
                    fr.push_back(din);
                    if (fr.size() == 4) begin
                        for (int i = 0; i < 4; i++) exp_q[i] = fr[i];
                        exp_qv = 1'b1;
                        fr.delete();
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("q0", 32'(q0), 32'(exp_q[0]));
            check("q1", 32'(q1), 32'(exp_q[1]));
            check("q2", 32'(q2), 32'(exp_q[2]));
            check("q3", 32'(q3), 32'(exp_q[3]));
            check("q_valid", 32'(q_valid), 32'(exp_qv));
            check("sync_err", 32'(sync_err), 32'(exp_err));
            check("locked", 32'(locked), 32'(exp_locked));
            check("slot", 32'(slot), 32'(exp_slot()));
            check("w1_q0", 32'(b0), 32'(exp_q[0][0]));
            check("w1_q1", 32'(b1), 32'(exp_q[1][0]));
            check("w1_q2", 32'(b2), 32'(exp_q[2][0]));
            check("w1_q3", 32'(b3), 32'(exp_q[3][0]));
            check("w1_q_valid", 32'(bq_valid), 32'(exp_qv));
            check("w1_sync_err", 32'(bsync_err), 32'(exp_err));
            check("w1_locked", 32'(blocked), 32'(exp_locked));
            check("w1_slot", 32'(bslot), 32'(exp_slot()));
        end
    end

    // Called at a negedge; returns at the next negedge with outputs settled.
    task automatic beat(input logic [7:0] d, input logic fs);
        din        = d;
        din_valid  = 1'b1;
        frame_sync = fs;
        @(negedge clk);
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic lit_q(input string name, input logic [7:0] e0, input logic [7:0] e1,
                         input logic [7:0] e2, input logic [7:0] e3);
        check({name, "_q0"}, 32'(q0), 32'(e0));
        check({name, "_q1"}, 32'(q1), 32'(e1));
        check({name, "_q2"}, 32'(q2), 32'(e2));
        check({name, "_q3"}, 32'(q3), 32'(e3));
    endtask

    initial begin
        logic [7:0] d;
        logic       fs;

        // Reset state
        @(negedge clk);
        gap(2);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_slot", 32'(slot), 32'd0);
        lit_q("rst", 8'h00, 8'h00, 8'h00, 8'h00);
        rst = 1'b0;

        // Nominal frame; W=1 sees 1,0,1,1
        beat(8'h01, 1'b1);
        beat(8'h00, 1'b0);
        beat(8'h01, 1'b0);
        check("nom_qv_before", 32'(q_valid), 32'd0);
        beat(8'h01, 1'b0);
        check("nom_qv", 32'(q_valid), 32'd1);
        check("nom_w1", 32'({b0, b1, b2, b3}), 32'b1011);
        check("nom_slot", 32'(slot), 32'd0);
        check("nom_locked", 32'(locked), 32'd1);
        gap(1);
        check("nom_qv_once", 32'(q_valid), 32'd0);

        // Gapped frame
        beat(8'h11, 1'b1); gap(3);
        beat(8'h20, 1'b0); gap(3);
        check("gap_slot", 32'(slot), 32'd2);
        lit_q("gap_hold", 8'h01, 8'h00, 8'h01, 8'h01);
        beat(8'h31, 1'b0); gap(3);
        beat(8'h41, 1'b0);
        check("gap_qv", 32'(q_valid), 32'd1);
        lit_q("gap", 8'h11, 8'h20, 8'h31, 8'h41);
        gap(3);

        // Early sync at slot 2
        beat(8'h11, 1'b1);
        beat(8'h22, 1'b0);
        beat(8'h33, 1'b1);
        check("early_err", 32'(sync_err), 32'd1);
        check("early_qv", 32'(q_valid), 32'd0);
        check("early_slot", 32'(slot), 32'd1);
        beat(8'h44, 1'b0);
        beat(8'h55, 1'b0);
        beat(8'h66, 1'b0);
        check("resync_qv", 32'(q_valid), 32'd1);
        lit_q("resync", 8'h33, 8'h44, 8'h55, 8'h66);

        // Missing sync after a completed frame
        beat(8'h77, 1'b0);
        check("miss_err", 32'(sync_err), 32'd1);
        check("miss_locked", 32'(locked), 32'd0);
        beat(8'h88, 1'b0);
        check("miss_ignored_err", 32'(sync_err), 32'd0);
        check("miss_ignored_slot", 32'(slot), 32'd0);

        // Reset mid-frame with a simultaneous valid beat
        beat(8'h12, 1'b1);
        beat(8'h34, 1'b0);
        rst = 1'b1;
        beat(8'h56, 1'b0);
        rst = 1'b0;
        check("mrst_locked", 32'(locked), 32'd0);
        check("mrst_slot", 32'(slot), 32'd0);
        check("mrst_err", 32'(sync_err), 32'd0);
        check("mrst_qv", 32'(q_valid), 32'd0);
        lit_q("mrst", 8'h00, 8'h00, 8'h00, 8'h00);

        // First beat right after reset, then back-to-back wide frames
        beat(8'hA5, 1'b1);
        beat(8'h3C, 1'b0);
        beat(8'hFF, 1'b0);
        beat(8'h00, 1'b0);
        check("wide_qv", 32'(q_valid), 32'd1);
        lit_q("wide", 8'hA5, 8'h3C, 8'hFF, 8'h00);
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < 4; s++) begin
                beat(8'(f * 16 + s + 1), s == 0);
                check("b2b_qv", 32'(q_valid), 32'(s == 3));
            end
        end
        lit_q("b2b", 8'h21, 8'h22, 8'h23, 8'h24);

        // Randomized traffic, mostly well-framed, with occasional resets
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 149) == 0) rst = 1'b1;
            d  = 8'($urandom);
            if ($urandom_range(0, 9) < 8) fs = (exp_slot() == 0);
            else fs = 1'($urandom);
            if ($urandom_range(0, 9) < 6) beat(d, fs);
            else begin
                din = d;
                frame_sync = fs;
                gap(1);
                frame_sync = 1'b0;
            end
            rst = 1'b0;
        end

        gap(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
